wb_sram_burst_slave: RTL and testbench
======================================

# wb_sram_burst_slave

Wishbone B4 registered-feedback slave that terminates one interconnect slave port (s0..s7) and drives a single-port synchronous SRAM macro with 1-cycle read latency. It supports classic cycles and incrementing bursts (CTI=3'b010) with linear or wrap-4/8/16 addressing (BTE). Bursts run at one beat per cycle after the first beat. It is the standard memory endpoint that sits directly downstream of the 4x8 interconnect.

## Interface
- WB_ADDR_WIDTH, 32: Wishbone byte-address width.
- WB_DATA_WIDTH, 32: data width; must be 8, 16, 32 or 64.
- MEM_ADDR_WIDTH, 10: SRAM word-address width (depth 2**MEM_ADDR_WIDTH words).
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s  wb_if.slave  -  Wishbone slave port: ADR, CTI, BTE, DAT_W, CYC, SEL, STB and WE are inputs; DAT_R, ACK and ERR are outputs.
- mem_en  out  1  SRAM access enable.
- mem_addr  out  MEM_ADDR_WIDTH  SRAM word address.
- mem_we  out  WB_DATA_WIDTH/8  per-byte write enable (0 = read).
- mem_wdata  out  WB_DATA_WIDTH  write data.
- mem_rdata  in  WB_DATA_WIDTH  read data, valid the cycle after a read with mem_en=1.

## Operation
- Word index: ADR[MEM_ADDR_WIDTH+B-1:B], where B = log2(WB_DATA_WIDTH/8). Upper ADR bits are ignored because the interconnect has already decoded them.
- ERR is tied to 0.
- States: IDLE, RD0, RD, WR.
- IDLE: when CYC&STB is high, capture the word index into addr counter `cur` and capture BTE.
  - If WE=1, next state is WR.
  - If WE=0, next state is RD0.
  - mem_en=0 in IDLE.
- WR: ACK = CYC&STB (combinational).
  - When ACK=1: mem_en=1, mem_addr=cur, mem_we=SEL, mem_wdata=DAT_W.
  - On ACK with live CTI==3'b010: stay in WR and set cur to next(cur).
  - On ACK with any other CTI: go to IDLE.
- RD0: mem_en=1, mem_addr=cur, mem_we=0; always go to RD.
- RD: ACK = CYC&STB and DAT_R = mem_rdata.
  - mem_en=1 every cycle. mem_addr = ACK ? next(cur) : cur. While the master inserts wait states (STB=0), the same word is re-read, so data stays valid.
  - On ACK with live CTI==3'b010: stay in RD and set cur to next(cur).
  - On ACK with any other CTI: go to IDLE. The speculative read of next(cur) is discarded and has no side effect.
- next(cur), by the BTE captured at burst start:
  - 00: cur+1, modulo 2**MEM_ADDR_WIDTH.
  - 01: low 2 bits +1 mod 4, upper bits unchanged.
  - 10: low 3 bits +1 mod 8, upper bits unchanged.
  - 11: low 4 bits +1 mod 16, upper bits unchanged.
- WE is only evaluated in IDLE. Changing WE mid-burst is illegal and is ignored.
- CYC=0 in any non-IDLE state: no ACK, no SRAM write, next state IDLE.
- DAT_R = 0 whenever ACK=0.

## Timing
- Reset (rst=1 at an edge):
  - State becomes IDLE, cur=0, captured BTE=0.
  - During and after reset until a new request: ACK=0, ERR=0, DAT_R=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-burst aborts immediately; no further ACK or write occurs.
- Classic write: request sampled at edge of cycle N; ACK and SRAM write in cycle N+1; IDLE in cycle N+2. A new request is accepted no earlier than N+2.
- Classic read: request sampled at N; SRAM read issued in N+1; ACK with data in N+2.
- Burst write: beats acknowledged in N+1, N+2, … (one per cycle while STB=1).
- Burst read: beats acknowledged in N+2, N+3, … (one per cycle while STB=1).
- A master wait state (STB=0) inserts exactly one idle cycle with no ACK. The counter holds.
- The last beat is the one carrying CTI=3'b111 (or 3'b000). That beat is acknowledged and the block returns to IDLE in the following cycle.
- ACK is never asserted in IDLE or RD0.

## Test plan
- Classic write: 0xDEADBEEF to ADR 0x40 with SEL=4'hF -> ACK for 1 cycle, 1 cycle after the request; mem_addr=0x10, mem_we=4'hF. A classic read of 0x40 then returns 0xDEADBEEF with ACK 2 cycles after the request.
- Wrap-4 read burst from ADR 0x18 (word 6, BTE=01, CTI 010,010,010,111) -> 4 consecutive ACKs returning words 6,7,4,5; IDLE afterwards.
- Linear 4-beat write burst from word 0x3FE with SEL=4'b0011 -> writes words 0x3FE, 0x3FF, 0x000, 0x001 (address wrap); only bytes 0-1 change.
- Read burst with STB dropped for 2 cycles after beat 2 -> no ACK during the gap; beat 3 returns the correct next word with no skipped or duplicated word.
- CYC dropped after 2 of 8 write beats -> exactly 2 words written; state IDLE next cycle; a following classic read completes normally.
- rst pulsed mid read burst -> ACK=0 and mem_en=0 on the next cycle. The next request starts from its own ADR, not the stale counter.

Source files
------------

// File: rtl/wb_sram_burst_slave_if.sv
// rtl/wb_sram_burst_slave_if.sv - Wishbone B4 bus bundle with master and slave views
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic                    ack;
  logic                    err;

  modport master (
    output adr, cti, bte, dat_w, cyc, sel, stb, we,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, cti, bte, dat_w, cyc, sel, stb, we,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_sram_burst_slave.sv
// rtl/wb_sram_burst_slave.sv - Wishbone B4 registered-feedback burst slave driving a 1-cycle-latency SRAM
module wb_sram_burst_slave #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  wb_if.slave                        s,
  output logic                       mem_en,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [WB_DATA_WIDTH/8-1:0] mem_we,
  output logic [WB_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [WB_DATA_WIDTH-1:0]   mem_rdata
);
  localparam int B = $clog2(WB_DATA_WIDTH / 8);
  localparam logic [2:0] CTI_INC = 3'b010;

  typedef enum logic [1:0] {IDLE, RD0, RD, WR} state_t;

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [1:0]                bte_q, bte_d;
  logic [MEM_ADDR_WIDTH-1:0] wrap_mask;
  logic [MEM_ADDR_WIDTH-1:0] nxt;
  logic [MEM_ADDR_WIDTH-1:0] word_idx;
  logic                      unused_adr;

  // Upper address bits were already decoded by the interconnect.
  assign word_idx   = s.adr[MEM_ADDR_WIDTH+B-1:B];
  assign unused_adr = ^s.adr;
  assign s.err      = 1'b0;

  always_comb begin
    wrap_mask = '1;
    unique case (bte_q)
      2'b01:   wrap_mask = MEM_ADDR_WIDTH'(3);
      2'b10:   wrap_mask = MEM_ADDR_WIDTH'(7);
      2'b11:   wrap_mask = MEM_ADDR_WIDTH'(15);
      default: wrap_mask = '1;
    endcase
  end

  // Increment only inside the wrap window; bits above it are preserved.
  assign nxt = (cur_q & ~wrap_mask) | ((cur_q + MEM_ADDR_WIDTH'(1)) & wrap_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      bte_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      bte_q   <= bte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    bte_d     = bte_q;
    s.ack     = 1'b0;
    s.dat_r   = '0;
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_we    = '0;
    mem_wdata = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (s.cyc && s.stb) begin
            cur_d   = word_idx;
            bte_d   = s.bte;
            state_d = s.we ? WR : RD0;
          end
        end
        WR: begin
          if (!s.cyc) begin
            state_d = IDLE;
          end else if (s.stb) begin
            s.ack     = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = cur_q;
            mem_we    = s.sel;
            mem_wdata = s.dat_w;
            if (s.cti == CTI_INC) cur_d = nxt;
            else state_d = IDLE;
          end
        end
        RD0: begin
          if (!s.cyc) begin
            state_d = IDLE;
          end else begin
            mem_en   = 1'b1;
            mem_addr = cur_q;
            state_d  = RD;
          end
        end
        RD: begin
          if (!s.cyc) begin
            state_d = IDLE;
          end else begin
            // Prefetch the next word on ACK; re-read the current one during wait states.
            mem_en   = 1'b1;
            mem_addr = s.stb ? nxt : cur_q;
            if (s.stb) begin
              s.ack   = 1'b1;
              s.dat_r = mem_rdata;
              if (s.cti == CTI_INC) cur_d = nxt;
              else state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_sram_burst_slave.sv
// tb/tb_wb_sram_burst_slave.sv - Randomized bench for wb_sram_burst_slave against a transaction-level memory model
module tb_wb_sram_burst_slave;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MAW   = 10;
  localparam int DEPTH = 1 << MAW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           preload = 1'b1;
  logic           mem_en;
  logic [MAW-1:0] mem_addr;
  logic [3:0]     mem_we;
  logic [31:0]    mem_wdata;
  logic [31:0]    mem_rdata;

  logic [31:0] sram    [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int errors = 0;
  int checks = 0;

  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_sram_burst_slave #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .MEM_ADDR_WIDTH(MAW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (bus),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int i);
    return 32'(i) * 32'h9E3779B9 ^ 32'h5A5A0000;
  endfunction

  // SRAM macro model: 1-cycle read latency, byte write enables
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= seed_word(i);
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= sram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Address of beat i of a burst starting at word 'start' under burst type b
  function automatic int exp_word(input int start, input logic [1:0] b, input int i);
    int n;
    if (b == 2'b00) return (start + i) % DEPTH;
    n = 2 << b;
    return start - (start % n) + ((start % n) + i) % n;
  endfunction

  task automatic check_idle();
    check("idle_ack",   64'(bus.ack),   64'd0);
    check("idle_err",   64'(bus.err),   64'd0);
    check("idle_dat_r", 64'(bus.dat_r), 64'd0);
    check("idle_en",    64'(mem_en),    64'd0);
    check("idle_we",    64'(mem_we),    64'd0);
    check("idle_addr",  64'(mem_addr),  64'd0);
    check("idle_wdata", 64'(mem_wdata), 64'd0);
  endtask

  task automatic verify_mem();
    int diffs = 0;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) if (sram[i] !== ref_mem[i]) diffs++;
    check("mem_image", 64'(diffs), 64'd0);
  endtask

  task automatic run_burst(input bit is_wr, input int word, input logic [1:0] bte_v,
                           input int nbeats, input logic [3:0] sel_v, input int gap_at,
                           input int gap_len, input int abort_at, input bit abort_rst,
                           input logic [31:0] fdata, input bit fix);
    int acked = 0;
    int cycles = 0;
    int gap_left = 0;
    int ew;
    bit got_ack;
    logic [31:0] wd;
    @(posedge clk); #1;
    wd          = fix ? fdata : $urandom;
    bus.cyc     = 1'b1;
    bus.stb     = 1'b1;
    bus.we      = is_wr;
    bus.bte     = bte_v;
    bus.sel     = sel_v;
    bus.adr     = 32'(word) << 2;
    bus.cti     = (nbeats == 1) ? 3'b000 : 3'b010;
    bus.dat_w   = wd;
    while (acked < nbeats) begin
      @(negedge clk);
      cycles++;
      got_ack = bus.ack;
      if (!bus.stb) check("gap_no_ack", 64'(bus.ack), 64'd0);
      if (got_ack) begin
        ew = exp_word(word, bte_v, acked);
        if (acked == 0) check(is_wr ? "wr_latency" : "rd_latency", 64'(cycles - 1), is_wr ? 64'd1 : 64'd2);
        if (is_wr) begin
          check("wr_en",   64'(mem_en),    64'd1);
          check("wr_addr", 64'(mem_addr),  64'(ew));
          check("wr_be",   64'(mem_we),    64'(sel_v));
          check("wr_data", 64'(mem_wdata), 64'(wd));
          for (int b = 0; b < 4; b++) if (sel_v[b]) ref_mem[ew][8*b +: 8] = wd[8*b +: 8];
        end else begin
          check("rd_data", 64'(bus.dat_r), 64'(ref_mem[ew]));
        end
        acked++;
      end else begin
        check("dat_r_noack", 64'(bus.dat_r), 64'd0);
      end
      if (cycles > 100) begin
        check("timeout", 64'(acked), 64'(nbeats));
        break;
      end
      @(posedge clk); #1;
      if (acked == nbeats) break;
      if (got_ack && acked == abort_at) begin
        if (abort_rst) rst = 1'b1;
        break;
      end
      if (got_ack && acked == gap_at) gap_left = gap_len;
      if (gap_left > 0) begin
        bus.stb = 1'b0;
        gap_left--;
      end else begin
        bus.stb = 1'b1;
      end
      if (got_ack) begin
        wd        = $urandom;
        bus.dat_w = wd;
        bus.adr   = 32'(exp_word(word, bte_v, acked)) << 2;
        bus.cti   = (acked == nbeats - 1) ? 3'b111 : 3'b010;
      end
    end
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
    bus.cti = 3'b000;
  endtask

  initial begin
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.cti = 3'b000; bus.bte = 2'b00;
    bus.sel = 4'h0; bus.adr = '0; bus.dat_w = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    check_idle();

    // Classic write then classic read of byte address 0x40
    run_burst(1'b1, 'h10, 2'b00, 1, 4'hF, -1, 0, -1, 1'b0, 32'hDEADBEEF, 1'b1);
    verify_mem();
    check("classic_ref", 64'(ref_mem['h10]), 64'hDEADBEEF);
    run_burst(1'b0, 'h10, 2'b00, 1, 4'hF, -1, 0, -1, 1'b0, 32'h0, 1'b0);

    // Wrap-4 read from word 6
    run_burst(1'b0, 6, 2'b01, 4, 4'hF, -1, 0, -1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("post_burst_ack", 64'(bus.ack), 64'd0);

    // Linear write wrapping the top of memory, low two bytes only
    run_burst(1'b1, 'h3FE, 2'b00, 4, 4'b0011, -1, 0, -1, 1'b0, 32'h0, 1'b0);
    verify_mem();

    // Read burst with a two-cycle master wait state after beat 2
    run_burst(1'b0, 'h20, 2'b00, 6, 4'hF, 2, 2, -1, 1'b0, 32'h0, 1'b0);

    // CYC dropped after 2 of 8 write beats
    run_burst(1'b1, 'h80, 2'b00, 8, 4'hF, -1, 0, 2, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("abort_ack", 64'(bus.ack), 64'd0);
    check("abort_we",  64'(mem_we),  64'd0);
    verify_mem();
    run_burst(1'b0, 'h81, 2'b00, 1, 4'hF, -1, 0, -1, 1'b0, 32'h0, 1'b0);

    // Reset pulsed in the middle of a read burst
    run_burst(1'b0, 'h100, 2'b00, 8, 4'hF, -1, 0, 3, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    check("rst_ack", 64'(bus.ack), 64'd0);
    check("rst_en",  64'(mem_en),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle();
    run_burst(1'b0, 'h200, 2'b00, 1, 4'hF, -1, 0, -1, 1'b0, 32'h0, 1'b0);
    run_burst(1'b0, 'h2F5, 2'b11, 4, 4'hF, -1, 0, -1, 1'b0, 32'h0, 1'b0);

    // Randomized mix of classic/burst reads and writes
    for (int t = 0; t < 40; t++) begin
      bit          r_wr;
      int          r_word, r_beats, r_gap_at, r_gap_len;
      logic [1:0]  r_bte;
      logic [3:0]  r_sel;
      r_wr      = 1'($urandom_range(0, 1));
      r_word    = $urandom_range(0, DEPTH - 1);
      r_bte     = 2'($urandom_range(0, 3));
      r_beats   = $urandom_range(1, 8);
      r_sel     = 4'($urandom_range(1, 15));
      r_gap_at  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : -1;
      r_gap_len = $urandom_range(1, 3);
      run_burst(r_wr, r_word, r_bte, r_beats, r_sel, r_gap_at, r_gap_len, -1, 1'b0, 32'h0, 1'b0);
      if (r_wr) verify_mem();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
